hsv_blob_tracker: RTL and testbench

Downstream consumer of the per-pixel RGB-to-HSV converter. It receives a streamed HSV pixel per valid cycle and classifies each pixel against programmable hue/saturation/value thresholds. The result is a registered binary mask stream. Over each frame it accumulates the matching-pixel count and bounding box, and publishes them at end of frame for the game/overlay logic.

---
 rtl/hsv_pkg.sv | 18 +
 rtl/hsv_match.sv | 23 ++
 rtl/hsv_blob_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_hsv_blob_tracker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV colour tracking blocks.
package hsv_pkg;

  localparam int CH_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Default thresholds select saturated, reasonably bright red.
  localparam logic [CH_W-1:0] H_LO  = 8'd240;
  localparam logic [CH_W-1:0] H_HI  = 8'd10;
  localparam logic [CH_W-1:0] S_MIN = 8'd100;
  localparam logic [CH_W-1:0] V_MIN = 8'd60;

endpackage

// File: rtl/hsv_match.sv
// Combinational HSV window test; a hue window with lo > hi wraps through 0.
module hsv_match
  import hsv_pkg::*;
(
  input  logic [CH_W-1:0] h,
  input  logic [CH_W-1:0] s,
  input  logic [CH_W-1:0] v,
  input  logic [CH_W-1:0] h_lo,
  input  logic [CH_W-1:0] h_hi,
  input  logic [CH_W-1:0] s_min,
  input  logic [CH_W-1:0] v_min,
  output logic            match
);

  logic hue_in;

  always_comb begin
    if (h_lo <= h_hi) hue_in = (h >= h_lo) && (h <= h_hi);
    else              hue_in = (h >= h_lo) || (h <= h_hi);
    match = hue_in && (s >= s_min) && (v >= v_min);
  end

endmodule

// File: rtl/hsv_blob_tracker.sv
// Per-pixel HSV mask plus per-frame matching-pixel count and bounding box.
// Stream: a pixel is accepted on every cycle with i_valid=1 (no back-pressure).
module hsv_blob_tracker
  import hsv_pkg::*;
#(
  parameter  int WIDTH      = 640,
  parameter  int HEIGHT     = 480,
  parameter  int MIN_PIXELS = 64,
  localparam int XW         = $clog2(WIDTH),
  localparam int YW         = $clog2(HEIGHT),
  localparam int CW         = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_sof,
  input  logic [CH_W-1:0] i_H,
  input  logic [CH_W-1:0] i_S,
  input  logic [CH_W-1:0] i_V,
  input  logic [CH_W-1:0] i_h_lo,
  input  logic [CH_W-1:0] i_h_hi,
  input  logic [CH_W-1:0] i_s_min,
  input  logic [CH_W-1:0] i_v_min,
  output logic            o_mask,
  output logic            o_mask_valid,
  output logic [XW-1:0]   o_x_min,
  output logic [XW-1:0]   o_x_max,
  output logic [YW-1:0]   o_y_min,
  output logic [YW-1:0]   o_y_max,
  output logic [CW-1:0]   o_pix_count,
  output logic            o_found,
  output logic            o_box_valid,
  output logic            o_frame_err,
  output state_e          o_state
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT-1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_PIXELS);

  state_e          state_q, state_d;
  logic [CH_W-1:0] sh_h_lo, sh_h_hi, sh_s_min, sh_v_min;
  logic [CH_W-1:0] eff_h_lo, eff_h_hi, eff_s_min, eff_v_min;
  logic            sof_px, match, last_px;
  logic [XW-1:0]   x_q, cur_x;
  logic [YW-1:0]   y_q, cur_y;
  logic            init_acc, acc_en, publish, abort;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   acc_x_min, acc_x_max;
  logic [YW-1:0]   acc_y_min, acc_y_max;

  assign sof_px = i_valid && i_sof;

  // The sof pixel is classified with the thresholds it is delivering.
  assign eff_h_lo  = sof_px ? i_h_lo  : sh_h_lo;
  assign eff_h_hi  = sof_px ? i_h_hi  : sh_h_hi;
  assign eff_s_min = sof_px ? i_s_min : sh_s_min;
  assign eff_v_min = sof_px ? i_v_min : sh_v_min;

  hsv_match u_match (
    .h     (i_H),
    .s     (i_S),
    .v     (i_V),
    .h_lo  (eff_h_lo),
    .h_hi  (eff_h_hi),
    .s_min (eff_s_min),
    .v_min (eff_v_min),
    .match (match)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_h_lo  <= '0;
      sh_h_hi  <= '0;
      sh_s_min <= '0;
      sh_v_min <= '0;
    end else if (sof_px) begin
      sh_h_lo  <= i_h_lo;
      sh_h_hi  <= i_h_hi;
      sh_s_min <= i_s_min;
      sh_v_min <= i_v_min;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mask       <= 1'b0;
      o_mask_valid <= 1'b0;
    end else begin
      o_mask       <= i_valid && match;
      o_mask_valid <= i_valid;
    end
  end

  // x_q/y_q hold the position the next non-sof pixel will take.
  assign cur_x   = i_sof ? '0 : x_q;
  assign cur_y   = i_sof ? '0 : y_q;
  assign last_px = (cur_x == X_LAST) && (cur_y == Y_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_valid) begin
      if (cur_x == X_LAST) begin
        x_q <= '0;
        y_q <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_q <= cur_x + XW'(1);
        y_q <= cur_y;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    init_acc = 1'b0;
    acc_en   = 1'b0;
    publish  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_px) begin
          state_d  = ACTIVE;
          init_acc = 1'b1;
        end
      end
      ACTIVE: begin
        if (sof_px) begin
          abort    = 1'b1;
          init_acc = 1'b1;
        end else if (i_valid) begin
          acc_en = 1'b1;
          if (last_px) state_d = DONE;
        end
      end
      DONE: begin
        publish = 1'b1;
        if (sof_px) begin
          state_d  = ACTIVE;
          init_acc = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_state = state_q;

  // An empty frame keeps inverted bounds so the first match sets all four.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
    end else if (init_acc) begin
      if (match) begin
        cnt       <= CW'(1);
        acc_x_min <= '0;
        acc_x_max <= '0;
        acc_y_min <= '0;
        acc_y_max <= '0;
      end else begin
        cnt       <= '0;
        acc_x_min <= X_LAST;
        acc_x_max <= '0;
        acc_y_min <= Y_LAST;
        acc_y_max <= '0;
      end
    end else if (acc_en && match) begin
      cnt <= cnt + CW'(1);
      if (cur_x < acc_x_min) acc_x_min <= cur_x;
      if (cur_x > acc_x_max) acc_x_max <= cur_x;
      if (cur_y < acc_y_min) acc_y_min <= cur_y;
      if (cur_y > acc_y_max) acc_y_max <= cur_y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x_min     <= '0;
      o_x_max     <= '0;
      o_y_min     <= '0;
      o_y_max     <= '0;
      o_pix_count <= '0;
      o_found     <= 1'b0;
      o_box_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_box_valid <= publish;
      o_frame_err <= abort;
      if (publish) begin
        o_pix_count <= cnt;
        o_found     <= (cnt >= MIN_C);
        if (cnt == '0) begin
          o_x_min <= '0;
          o_x_max <= '0;
          o_y_min <= '0;
          o_y_max <= '0;
        end else begin
          o_x_min <= acc_x_min;
          o_x_max <= acc_x_max;
          o_y_min <= acc_y_min;
          o_y_max <= acc_y_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Scoreboard bench for hsv_blob_tracker on an 8x4 frame with a list-based frame model.
module tb_hsv_blob_tracker;
  import hsv_pkg::*;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int MINP = 2;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int CW   = $clog2(W*H+1);
  localparam int BW   = 1 + CW + 2*XW + 2*YW;
  localparam int NPIX = W*H;

  logic          clk, rst_n;
  logic          i_valid, i_sof;
  logic [7:0]    i_H, i_S, i_V, i_h_lo, i_h_hi, i_s_min, i_v_min;
  logic          o_mask, o_mask_valid, o_found, o_box_valid, o_frame_err;
  logic [XW-1:0] o_x_min, o_x_max;
  logic [YW-1:0] o_y_min, o_y_max;
  logic [CW-1:0] o_pix_count;
  state_e        o_state;

  hsv_blob_tracker #(.WIDTH(W), .HEIGHT(H), .MIN_PIXELS(MINP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof),
    .i_H(i_H), .i_S(i_S), .i_V(i_V),
    .i_h_lo(i_h_lo), .i_h_hi(i_h_hi), .i_s_min(i_s_min), .i_v_min(i_v_min),
    .o_mask(o_mask), .o_mask_valid(o_mask_valid),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_pix_count(o_pix_count), .o_found(o_found),
    .o_box_valid(o_box_valid), .o_frame_err(o_frame_err), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0]    exp_mask_q[$];
  logic [BW-1:0] exp_box_q[$];
  logic [0:0]    exp_err_q[$];

  // reference model: frame = ordered list of valid pixels since the last sof
  logic [7:0] m_hlo, m_hhi, m_smin, m_vmin;
  bit         m_active;
  int         m_idx;
  int         mx[$], my[$];

  logic [7:0] px_h[NPIX], px_s[NPIX], px_v[NPIX];

  function automatic bit ref_match(input logic [7:0] h, s, v, lo, hi, smin, vmin);
    bit hue;
    if (lo <= hi) hue = (h >= lo) && (h <= hi);
    else          hue = (h >= lo) || (h <= hi);
    return hue && (s >= smin) && (v >= vmin);
  endfunction

  function automatic logic [BW-1:0] frame_summary();
    int n, xmn, xmx, ymn, ymx;
    n = mx.size();
    if (n == 0) return '0;
    xmn = W; xmx = -1; ymn = H; ymx = -1;
    foreach (mx[i]) begin
      if (mx[i] < xmn) xmn = mx[i];
      if (mx[i] > xmx) xmx = mx[i];
      if (my[i] < ymn) ymn = my[i];
      if (my[i] > ymx) ymx = my[i];
    end
    return {(n >= MINP), CW'(n), XW'(xmn), XW'(xmx), YW'(ymn), YW'(ymx)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic pix(input bit sof, input logic [7:0] h, s, v);
    bit mt;
    @(negedge clk);
    i_valid = 1'b1; i_sof = sof; i_H = h; i_S = s; i_V = v;
    if (sof) begin
      m_hlo = i_h_lo; m_hhi = i_h_hi; m_smin = i_s_min; m_vmin = i_v_min;
      if (m_active) exp_err_q.push_back(1'b1);
      m_active = 1'b1;
      m_idx = 0;
      mx.delete();
      my.delete();
    end
    mt = ref_match(h, s, v, m_hlo, m_hhi, m_smin, m_vmin);
    exp_mask_q.push_back(mt);
    if (m_active) begin
      if (mt) begin
        mx.push_back(m_idx % W);
        my.push_back(m_idx / W);
      end
      m_idx++;
      if (m_idx == NPIX) begin
        exp_box_q.push_back(frame_summary());
        m_active = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0; i_sof = 1'b0;
    end
  endtask

  task automatic set_thr(input logic [7:0] lo, hi, smin, vmin);
    i_h_lo = lo; i_h_hi = hi; i_s_min = smin; i_v_min = vmin;
  endtask

  // pixels first..NPIX-1 of px_*; first is sent with sof
  task automatic send_frame(input int first, input bit gaps, input bit thr_chg);
    for (int i = first; i < NPIX; i++) begin
      pix(i == first, px_h[i], px_s[i], px_v[i]);
      if (thr_chg && i == first + 5)
        set_thr(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic fill_nomatch();
    for (int i = 0; i < NPIX; i++) begin
      px_h[i] = 8'($urandom_range(50, 200));
      px_s[i] = 8'($urandom);
      px_v[i] = 8'($urandom);
    end
  endtask

  task automatic fill_frame_a();
    fill_nomatch();
    foreach (px_h[i]) if (i == 1*W+2 || i == 1*W+5 || i == 2*W+3) begin
      px_h[i] = 8'($urandom_range(20, 40));
      px_s[i] = 8'($urandom_range(100, 255));
      px_v[i] = 8'($urandom_range(100, 255));
    end
  endtask

  task automatic check_published(input string tag, input int xmn, xmx, ymn, ymx, cnt, fnd);
    check({tag, "_x_min"}, int'(o_x_min), xmn);
    check({tag, "_x_max"}, int'(o_x_max), xmx);
    check({tag, "_y_min"}, int'(o_y_min), ymn);
    check({tag, "_y_max"}, int'(o_y_max), ymx);
    check({tag, "_count"}, int'(o_pix_count), cnt);
    check({tag, "_found"}, int'(o_found), fnd);
  endtask

  task automatic check_all_zero(input string tag);
    check_published(tag, 0, 0, 0, 0, 0, 0);
    check({tag, "_mask_valid"}, int'(o_mask_valid), 0);
    check({tag, "_mask"}, int'(o_mask), 0);
    check({tag, "_box_valid"}, int'(o_box_valid), 0);
    check({tag, "_frame_err"}, int'(o_frame_err), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_mask_valid) begin
        n_tests++;
        if (exp_mask_q.size() == 0) begin
          n_fail++;
          $display("FAIL mask: got unexpected mask_valid, mask=%0b", o_mask);
        end else begin
          logic [0:0] e;
          e = exp_mask_q.pop_front();
          if (o_mask !== e) begin
            n_fail++;
            $display("FAIL mask: got %0b expected %0b", o_mask, e);
          end
        end
      end
      if (o_box_valid) begin
        n_tests++;
        if (exp_box_q.size() == 0) begin
          n_fail++;
          $display("FAIL box: got unexpected box_valid pulse");
        end else begin
          logic [BW-1:0] e, a;
          e = exp_box_q.pop_front();
          a = {o_found, o_pix_count, o_x_min, o_x_max, o_y_min, o_y_max};
          if (a !== e) begin
            n_fail++;
            $display("FAIL box: got %h expected %h", a, e);
          end
        end
      end
      if (o_frame_err) begin
        n_tests++;
        if (exp_err_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_err: got unexpected pulse");
        end else begin
          void'(exp_err_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_H = '0; i_S = '0; i_V = '0;
    set_thr(H_LO, H_HI, S_MIN, V_MIN);
    m_hlo = '0; m_hhi = '0; m_smin = '0; m_vmin = '0;
    m_active = 1'b0; m_idx = 0;
    #1;
    check_all_zero("reset");
    check("reset_state", int'(o_state), int'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // three matching pixels in a sparse frame
    set_thr(8'd20, 8'd40, 8'd100, 8'd100);
    fill_frame_a();
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_published("frame_a", 2, 5, 1, 2, 3, 1);

    // wrapped red window with its boundaries
    set_thr(8'd240, 8'd10, 8'd100, 8'd100);
    for (int i = 0; i < NPIX; i++) begin
      px_h[i] = 8'd128; px_s[i] = 8'd255; px_v[i] = 8'd255;
    end
    px_h[0] = 8'd250; px_h[1] = 8'd5; px_h[2] = 8'd128; px_h[3] = 8'd240; px_h[4] = 8'd10;
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_published("wrap", 0, 4, 0, 0, 4, 1);

    // empty frame still publishes, with zeroed box
    set_thr(8'd20, 8'd40, 8'd100, 8'd100);
    fill_nomatch();
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_published("empty", 0, 0, 0, 0, 0, 0);

    // second sof at (3,2) aborts, restarted frame publishes its own stats
    fill_frame_a();
    for (int i = 0; i < 2*W+3; i++) pix(i == 0, px_h[i], px_s[i], px_v[i]);
    fill_nomatch();
    px_h[NPIX-1] = 8'd30; px_s[NPIX-1] = 8'd200; px_v[NPIX-1] = 8'd200;
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_published("abort", W-1, W-1, H-1, H-1, 1, 0);

    // gaps and mid-frame threshold changes leave frame_a results unchanged
    set_thr(8'd20, 8'd40, 8'd100, 8'd100);
    fill_frame_a();
    send_frame(0, 1'b1, 1'b1);
    idle(3);
    check_published("gaps", 2, 5, 1, 2, 3, 1);

    // reset in the middle of a frame
    set_thr(8'd20, 8'd40, 8'd100, 8'd100);
    fill_frame_a();
    for (int i = 0; i < 12; i++) pix(i == 0, px_h[i], px_s[i], px_v[i]);
    idle(2);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_active = 1'b0;
    m_hlo = '0; m_hhi = '0; m_smin = '0; m_vmin = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_published("after_reset", 2, 5, 1, 2, 3, 1);

    // randomized frames, random thresholds, occasional aborts
    for (int f = 0; f < 6; f++) begin
      set_thr(8'($urandom), 8'($urandom), 8'($urandom_range(0, 200)), 8'($urandom_range(0, 200)));
      for (int i = 0; i < NPIX; i++) begin
        px_h[i] = 8'($urandom); px_s[i] = 8'($urandom); px_v[i] = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < $urandom_range(1, NPIX-2); i++) pix(i == 0, px_h[i], px_s[i], px_v[i]);
      send_frame(0, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(3);

    // drain with a bounded wait
    for (int t = 0; t < 50; t++) begin
      if (exp_mask_q.size() == 0 && exp_box_q.size() == 0 && exp_err_q.size() == 0) break;
      @(negedge clk);
    end
    check("mask_q_left", exp_mask_q.size(), 0);
    check("box_q_left", exp_box_q.size(), 0);
    check("err_q_left", exp_err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
